riscv_skid_stage: RTL and testbench
===================================

RISCV_SKID_STAGE -- requirements
Module: riscv_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default `XLEN, payload width in bits (>=1).
REQ-002 SHALL have parameter RESET_DATA, default 0, reset value of both data registers.
REQ-003 SHALL have parameter FLUSH_CLEARS, default 0; when 1, flush also loads RESET_DATA into both data registers.
REQ-004 SHALL have port i_clk, input, 1, the only clock; all state on rising edge.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_flush, input, 1, synchronous pipeline flush.
REQ-007 SHALL have port i_s_valid, input, 1, upstream data valid.
REQ-008 SHALL have port o_s_ready, output, 1, stage can accept.
REQ-009 SHALL have port i_s_data, input, WIDTH, upstream payload.
REQ-010 SHALL have port o_m_valid, output, 1, downstream data valid.
REQ-011 SHALL have port i_m_ready, input, 1, downstream accepts.
REQ-012 SHALL have port o_m_data, output, WIDTH, downstream payload.
REQ-013 SHALL have port o_count, output, 2, entries held (0..2).

Function
REQ-014 SHALL implement three states: EMPTY (0 entries), BUSY (main register valid), FULL (main and skid registers valid).
REQ-015 SHALL drive o_s_ready = (state != FULL) and o_m_valid = (state != EMPTY), both decoded from registered state only; no combinational path from i_m_ready to o_s_ready.
REQ-016 SHALL drive o_m_data from the main register only; o_count = 0/1/2 for EMPTY/BUSY/FULL.
REQ-017 SHALL define transfer-in = i_s_valid & o_s_ready and transfer-out = o_m_valid & i_m_ready.
REQ-018 EMPTY: transfer-in -> BUSY, main <= i_s_data; else stay.
REQ-019 BUSY: in & out -> BUSY, main <= i_s_data; in & !out -> FULL, skid <= i_s_data; !in & out -> EMPTY; neither -> stay.
REQ-020 FULL: out -> BUSY, main <= skid; no transfer-in possible; !out -> stay, both registers held.
REQ-021 SHALL provide latency of exactly 1 cycle from transfer-in to o_m_valid in EMPTY, and sustain 1 transfer per cycle while i_m_ready stays high.
REQ-022 SHALL preserve order and never drop or duplicate a payload absent flush.
REQ-023 i_flush SHALL take priority over all transfers: next state EMPTY; any same-cycle transfer-in is discarded; any same-cycle transfer-out counts as delivered.
REQ-024 With FLUSH_CLEARS=0 data registers SHALL hold their value on flush; with 1 they SHALL load RESET_DATA.
REQ-025 Data registers SHALL only be written on the cycles listed in REQ-018..020/024 (no toggling when idle).

Reset
REQ-026 i_rst asserted SHALL immediately force state EMPTY, main and skid to RESET_DATA, independent of i_clk.
REQ-027 During and after reset: o_m_valid=0, o_s_ready=1, o_count=0, o_m_data=RESET_DATA.
REQ-028 Reset asserted mid-transfer SHALL discard all held entries; first transfer-in after deassertion behaves as from EMPTY.

Structure
REQ-029 State encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) SHALL be shared localparams in the common riscv configuration header; `XLEN comes from the same header.
REQ-030 SHALL be a single module with one state register and two WIDTH-bit data registers; no sub-module required.

Verification
REQ-031 Reset, then i_s_valid=1, data 0xA5A5A5A5, i_m_ready=1 -> next cycle o_m_valid=1, o_m_data=0xA5A5A5A5, o_count=1.
REQ-032 Stream 0x1..0x8 back-to-back with i_m_ready=1 -> outputs 0x1..0x8 on consecutive cycles, o_s_ready constantly 1.
REQ-033 i_m_ready=0, push 0x11,0x22 -> o_count=2, o_s_ready=0, o_m_data=0x11; raise i_m_ready -> 0x11 then 0x22, o_s_ready back to 1 one cycle after first pop.
REQ-034 FULL with 0x33,0x44, assert i_flush with i_s_valid=1 data 0x55 -> next cycle o_count=0, o_m_valid=0; 0x55 never appears.
REQ-035 Random i_s_valid/i_m_ready for 10k cycles, RESET_DATA=0xDEAD, scoreboard -> in-order, no loss/duplication, o_s_ready never depends on same-cycle i_m_ready.
REQ-036 Assert i_rst asynchronously mid-cycle while FULL -> outputs reach reset values before next i_clk edge; o_m_data=0xDEAD.

Source files
------------

// File: rtl/riscv_skid_stage_pkg.sv
// rtl/riscv_skid_stage_pkg.sv - shared riscv configuration: XLEN and skid stage state encodings
`ifndef XLEN
`define XLEN 32
`endif

package riscv_skid_stage_pkg;

    localparam int XLEN = `XLEN;

    localparam logic [1:0] SKID_EMPTY = 2'd0;
    localparam logic [1:0] SKID_BUSY  = 2'd1;
    localparam logic [1:0] SKID_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = SKID_EMPTY,
        ST_BUSY  = SKID_BUSY,
        ST_FULL  = SKID_FULL
    } skid_state_t;

endpackage

// File: rtl/riscv_skid_stage.sv
// rtl/riscv_skid_stage.sv - two-entry skid buffer with registered ready/valid and synchronous flush
`ifndef XLEN
`define XLEN 32
`endif

module riscv_skid_stage
    import riscv_skid_stage_pkg::*;
#(
    parameter int               WIDTH        = `XLEN,
    parameter logic [WIDTH-1:0] RESET_DATA   = '0,
    parameter bit               FLUSH_CLEARS = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data,
    output logic [1:0]       o_count
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic xfer_in;
    logic xfer_out;
    logic main_load;
    logic main_from_skid;
    logic skid_load;
    logic clear_data;

    // Handshake outputs decode only the state register, so ready never sees i_m_ready.
    assign o_s_ready = (state_q != ST_FULL);
    assign o_m_valid = (state_q != ST_EMPTY);
    assign o_m_data  = main_q;
    assign o_count   = state_q;

    assign xfer_in  = i_s_valid & o_s_ready;
    assign xfer_out = o_m_valid & i_m_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        clear_data     = 1'b0;
        if (i_flush) begin
            state_d    = ST_EMPTY;
            clear_data = FLUSH_CLEARS;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d   = ST_BUSY;
                        main_load = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (xfer_in && xfer_out) begin
                        main_load = 1'b1;
                    end else if (xfer_in) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        state_d        = ST_BUSY;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_DATA;
            skid_q  <= RESET_DATA;
        end else begin
            state_q <= state_d;
            if (clear_data) begin
                main_q <= RESET_DATA;
                skid_q <= RESET_DATA;
            end else begin
                if (main_load) begin
                    main_q <= main_from_skid ? skid_q : i_s_data;
                end
                if (skid_load) begin
                    skid_q <= i_s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_skid_stage.sv
// tb/tb_riscv_skid_stage.sv - directed vector table, async reset check and randomized queue-model scoreboard
module tb_riscv_skid_stage;

    localparam logic [31:0] RD = 32'hDEAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        m_ready = 1'b0;
    logic        s_ready, m_valid, s_ready2, m_valid2;
    logic [31:0] m_data, m_data2;
    logic [1:0]  count, count2;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    riscv_skid_stage #(.WIDTH(32), .RESET_DATA(RD), .FLUSH_CLEARS(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_count(count)
    );

    riscv_skid_stage #(.WIDTH(32), .RESET_DATA(RD), .FLUSH_CLEARS(1'b1)) dut_clr (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_s_valid(s_valid), .o_s_ready(s_ready2), .i_s_data(s_data),
        .o_m_valid(m_valid2), .i_m_ready(m_ready), .o_m_data(m_data2),
        .o_count(count2)
    );

    typedef struct {
        logic        sv;
        logic [31:0] d;
        logic        mr;
        logic        fl;
        logic        ev;
        logic        er;
        logic [1:0]  ec;
        logic [31:0] ed;
        logic [31:0] ed2;
    } vec_t;

    vec_t vecs[$];

    // Reference model: an ordered queue of held payloads plus the last payload shown.
    logic [31:0] mq[$];
    logic [31:0] main_m;
    logic [31:0] main2_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        main_m  = RD;
        main2_m = RD;
    endtask

    task automatic model_update();
        bit tin, tout;
        tin  = s_valid && (mq.size() < 2);
        tout = m_ready && (mq.size() > 0);
        if (flush) begin
            mq.delete();
            main2_m = RD;
        end else begin
            if (tout) void'(mq.pop_front());
            if (tin) mq.push_back(s_data);
            if (mq.size() > 0) begin
                main_m  = mq[0];
                main2_m = mq[0];
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_valid", {31'd0, m_valid}, {31'd0, mq.size() > 0});
        chk("rnd_ready", {31'd0, s_ready}, {31'd0, mq.size() < 2});
        chk("rnd_count", {30'd0, count}, mq.size());
        chk("rnd_data", m_data, main_m);
        chk("rnd_data_clr", m_data2, main2_m);
    endtask

    task automatic step(input logic sv, input logic [31:0] d, input logic mr, input logic fl);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic add(input logic sv, input logic [31:0] d, input logic mr, input logic fl,
                       input logic ev, input logic er, input logic [1:0] ec,
                       input logic [31:0] ed, input logic [31:0] ed2);
        vec_t v;
        v.sv = sv; v.d = d; v.mr = mr; v.fl = fl;
        v.ev = ev; v.er = er; v.ec = ec; v.ed = ed; v.ed2 = ed2;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic r_a, r_b;
    int   seq;

    initial begin
        // Single push, stream of eight, fill/drain, flush of a full stage, flush with delivery
        add(1, 32'hA5A5A5A5, 1, 0, 1, 1, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
        for (int i = 1; i <= 8; i++) add(1, i, 1, 0, 1, 1, 1, i, i);
        add(0, 0, 1, 0, 0, 1, 0, 32'h8, 32'h8);
        add(1, 32'h11, 0, 0, 1, 1, 1, 32'h11, 32'h11);
        add(1, 32'h22, 0, 0, 1, 0, 2, 32'h11, 32'h11);
        add(0, 0, 1, 0, 1, 1, 1, 32'h22, 32'h22);
        add(0, 0, 1, 0, 0, 1, 0, 32'h22, 32'h22);
        add(1, 32'h33, 0, 0, 1, 1, 1, 32'h33, 32'h33);
        add(1, 32'h44, 0, 0, 1, 0, 2, 32'h33, 32'h33);
        add(1, 32'h55, 0, 1, 0, 1, 0, 32'h33, RD);
        add(0, 0, 1, 0, 0, 1, 0, 32'h33, RD);
        add(1, 32'h66, 0, 0, 1, 1, 1, 32'h66, 32'h66);
        add(0, 0, 1, 1, 0, 1, 0, 32'h66, RD);

        @(negedge clk);
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_ready", {31'd0, s_ready}, 32'd1);
        chk("reset_count", {30'd0, count}, 32'd0);
        chk("reset_data", m_data, RD);
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].sv, vecs[i].d, vecs[i].mr, vecs[i].fl);
            chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].er});
            chk($sformatf("vec%0d_count", i), {30'd0, count}, {30'd0, vecs[i].ec});
            chk($sformatf("vec%0d_data", i), m_data, vecs[i].ed);
            chk($sformatf("vec%0d_data_clr", i), m_data2, vecs[i].ed2);
        end

        // Asynchronous reset while full: outputs must settle before the next clock edge
        step(1, 32'h77, 0, 0);
        step(1, 32'h88, 0, 0);
        chk("full_count", {30'd0, count}, 32'd2);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, m_valid}, 32'd0);
        chk("async_ready", {31'd0, s_ready}, 32'd1);
        chk("async_count", {30'd0, count}, 32'd0);
        chk("async_data", m_data, RD);
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        step(1, 32'h99, 0, 0);
        chk("post_rst_count", {30'd0, count}, 32'd1);
        chk("post_rst_data", m_data, 32'h99);
        step(0, 0, 1, 0);
        chk("post_rst_drain", {30'd0, count}, 32'd0);

        // Randomized traffic against the queue model
        do_reset();
        seq = 1;
        for (int c = 0; c < 10000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = {$urandom_range(0, 255), 24'd0} | seq;
            m_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 63) == 0);
            if (s_valid) seq++;
            if ((c % 97) == 0) begin
                #1 r_a = s_ready;
                m_ready = ~m_ready;
                #1 r_b = s_ready;
                m_ready = ~m_ready;
                chk("ready_indep", {31'd0, r_b}, {31'd0, r_a});
            end
            @(posedge clk);
            model_update();
            @(negedge clk);
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
